// File: rtl/i2c_segment_display_ctrl.sv
// I2C target with a digit/control register file that drives a multiplexed
// multi-digit 7-segment display (hex-decode or raw-segment modes).
module i2c_segment_display_ctrl #(
    parameter logic [6:0]  I2C_ADDR   = 7'h2A,
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned MUX_DIV    = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_oe,
    output logic [7:0]            seg_out,
    output logic [NUM_DIGITS-1:0] digit_sel
);

    localparam int unsigned DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CW = $clog2(MUX_DIV);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ACK_A, S_PTR, S_ACK_P,
        S_WDATA, S_ACK_W, S_RDATA, S_ACKWAIT
    } state_t;

    // [0],[1] = synchroniser stages, [2] = previous value for edge detection
    logic [2:0] scl_sync_q, scl_sync_d;
    logic [2:0] sda_sync_q, sda_sync_d;

    state_t      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  shift_q, shift_d;
    logic [6:0]  tx_q, tx_d;
    logic [7:0]  ptr_q, ptr_d;
    logic        sda_oe_q, sda_oe_d;
    logic        ack_ph_q, ack_ph_d;
    logic        rw_q, rw_d;

    logic [7:0]  digit_q [NUM_DIGITS];
    logic [7:0]  digit_d [NUM_DIGITS];
    logic [1:0]  ctrl_q, ctrl_d;

    logic [CW-1:0]         mux_cnt_q, mux_cnt_d;
    logic [DW-1:0]         idx_q, idx_d;
    logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;
    logic [7:0]            seg_out_q, seg_out_d;

    logic       scl_rise, scl_fall, start_det, stop_det;
    logic       wr_en;
    logic [7:0] rx_byte, rd_byte, ptr_inc, cur_digit;

    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        case (n)
            4'h0: hex_glyph = 7'h3F;
            4'h1: hex_glyph = 7'h06;
            4'h2: hex_glyph = 7'h5B;
            4'h3: hex_glyph = 7'h4F;
            4'h4: hex_glyph = 7'h66;
            4'h5: hex_glyph = 7'h6D;
            4'h6: hex_glyph = 7'h7D;
            4'h7: hex_glyph = 7'h07;
            4'h8: hex_glyph = 7'h7F;
            4'h9: hex_glyph = 7'h6F;
            4'hA: hex_glyph = 7'h77;
            4'hB: hex_glyph = 7'h7C;
            4'hC: hex_glyph = 7'h39;
            4'hD: hex_glyph = 7'h5E;
            4'hE: hex_glyph = 7'h79;
            default: hex_glyph = 7'h71;
        endcase
    endfunction

    always_comb begin
        scl_sync_d = {scl_sync_q[1:0], scl_in};
        sda_sync_d = {sda_sync_q[1:0], sda_in};
    end

    assign scl_rise  =  scl_sync_q[1] & ~scl_sync_q[2];
    assign scl_fall  = ~scl_sync_q[1] &  scl_sync_q[2];
    assign start_det =  scl_sync_q[1] &  sda_sync_q[2] & ~sda_sync_q[1];
    assign stop_det  =  scl_sync_q[1] & ~sda_sync_q[2] &  sda_sync_q[1];
    assign rx_byte   = {shift_q, sda_sync_q[1]};
    assign ptr_inc   = (ptr_q >= 8'(NUM_DIGITS)) ? 8'h00 : ptr_q + 8'h01;

    always_comb begin
        rd_byte = '0;
        if (ptr_q < 8'(NUM_DIGITS))
            rd_byte = digit_q[ptr_q[DW-1:0]];
        else if (ptr_q == 8'(NUM_DIGITS))
            rd_byte = {6'b0, ctrl_q};
    end

    // Each ACK state sees two SCL falls: the first drives ACK low, the second
    // releases it (and, entering a read, presents the first data bit).
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        ptr_d     = ptr_q;
        sda_oe_d  = sda_oe_q;
        ack_ph_d  = ack_ph_q;
        rw_d      = rw_q;
        wr_en     = 1'b0;
        if (start_det) begin
            state_d   = S_ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            ack_ph_d  = 1'b0;
        end else if (stop_det) begin
            state_d  = S_IDLE;
            sda_oe_d = 1'b0;
            ack_ph_d = 1'b0;
        end else begin
            case (state_q)
                S_ADDR, S_PTR, S_WDATA: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = '0;
                            if (state_q == S_ADDR) begin
                                if (rx_byte[7:1] == I2C_ADDR) begin
                                    rw_d    = rx_byte[0];
                                    state_d = S_ACK_A;
                                end else begin
                                    state_d = S_IDLE;
                                end
                            end else if (state_q == S_PTR) begin
                                ptr_d   = rx_byte;
                                state_d = S_ACK_P;
                            end else begin
                                wr_en   = 1'b1;
                                ptr_d   = ptr_inc;
                                state_d = S_ACK_W;
                            end
                        end
                    end
                end
                S_ACK_A, S_ACK_P, S_ACK_W: begin
                    if (scl_fall) begin
                        if (!ack_ph_q) begin
                            sda_oe_d = 1'b1;
                            ack_ph_d = 1'b1;
                        end else begin
                            ack_ph_d = 1'b0;
                            sda_oe_d = 1'b0;
                            if (state_q == S_ACK_A && rw_q) begin
                                state_d  = S_RDATA;
                                tx_d     = rd_byte[6:0];
                                sda_oe_d = ~rd_byte[7];
                            end else if (state_q == S_ACK_A) begin
                                state_d = S_PTR;
                            end else begin
                                state_d = S_WDATA;
                            end
                        end
                    end
                end
                S_RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = S_ACKWAIT;
                        end else begin
                            tx_d     = {tx_q[5:0], 1'b0};
                            sda_oe_d = ~tx_q[6];
                        end
                    end
                end
                S_ACKWAIT: begin
                    if (scl_rise) begin
                        if (sda_sync_q[1]) begin
                            state_d = S_IDLE;
                        end else begin
                            ptr_d    = ptr_inc;
                            ack_ph_d = 1'b1;
                        end
                    end else if (scl_fall && ack_ph_q) begin
                        ack_ph_d = 1'b0;
                        state_d  = S_RDATA;
                        tx_d     = rd_byte[6:0];
                        sda_oe_d = ~rd_byte[7];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        digit_d = digit_q;
        ctrl_d  = ctrl_q;
        if (wr_en) begin
            if (ptr_q < 8'(NUM_DIGITS))
                digit_d[ptr_q[DW-1:0]] = rx_byte;
            else if (ptr_q == 8'(NUM_DIGITS))
                ctrl_d = rx_byte[1:0];
        end
    end

    // Segment pattern is derived from the next digit index so digit_sel and
    // seg_out switch together.
    always_comb begin
        mux_cnt_d = mux_cnt_q + CW'(1);
        idx_d     = idx_q;
        if (mux_cnt_q == CW'(MUX_DIV - 1)) begin
            mux_cnt_d = '0;
            idx_d     = (idx_q == DW'(NUM_DIGITS - 1)) ? '0 : idx_q + DW'(1);
        end
        digit_sel_d        = '0;
        digit_sel_d[idx_d] = 1'b1;
        cur_digit          = digit_q[idx_d];
        if (ctrl_q[1])
            seg_out_d = '0;
        else if (ctrl_q[0])
            seg_out_d = {cur_digit[7], hex_glyph(cur_digit[3:0])};
        else
            seg_out_d = cur_digit;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_sync_q  <= '1;
            sda_sync_q  <= '1;
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            tx_q        <= '0;
            ptr_q       <= '0;
            sda_oe_q    <= 1'b0;
            ack_ph_q    <= 1'b0;
            rw_q        <= 1'b0;
            digit_q     <= '{default: '0};
            ctrl_q      <= 2'b01;
            mux_cnt_q   <= '0;
            idx_q       <= '0;
            digit_sel_q <= NUM_DIGITS'(1);
            seg_out_q   <= '0;
        end else begin
            scl_sync_q  <= scl_sync_d;
            sda_sync_q  <= sda_sync_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            ptr_q       <= ptr_d;
            sda_oe_q    <= sda_oe_d;
            ack_ph_q    <= ack_ph_d;
            rw_q        <= rw_d;
            digit_q     <= digit_d;
            ctrl_q      <= ctrl_d;
            mux_cnt_q   <= mux_cnt_d;
            idx_q       <= idx_d;
            digit_sel_q <= digit_sel_d;
            seg_out_q   <= seg_out_d;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign seg_out   = seg_out_q;
    assign digit_sel = digit_sel_q;

endmodule

// File: tb/tb_i2c_segment_display_ctrl.sv
// Directed bench: bit-banged I2C controller with an open-drain SDA model,
// checking ACKs, read-back data and the multiplexed display.
module tb_i2c_segment_display_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_oe;
    logic       sda_line;
    logic [7:0] seg_out;
    logic [3:0] digit_sel;
    int         n_chk = 0;
    int         n_bad = 0;
    int         oe_cnt = 0;

    assign sda_line = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    always @(negedge clk) if (sda_oe) oe_cnt++;

    i2c_segment_display_ctrl #(
        .I2C_ADDR  (7'h2A),
        .NUM_DIGITS(4),
        .MUX_DIV   (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_in   (scl_m),
        .sda_in   (sda_line),
        .sda_oe   (sda_oe),
        .seg_out  (seg_out),
        .digit_sel(digit_sel)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic q_wait();
        repeat (8) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; scl_m = 1'b1; q_wait();
        sda_m = 1'b0; q_wait();
        scl_m = 1'b0; q_wait();
    endtask

    task automatic i2c_rstart();
        sda_m = 1'b1; q_wait();
        scl_m = 1'b1; q_wait();
        sda_m = 1'b0; q_wait();
        scl_m = 1'b0; q_wait();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; q_wait();
        scl_m = 1'b1; q_wait();
        sda_m = 1'b1; q_wait();
    endtask

    task automatic wr_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            sda_m = b[i]; q_wait();
            scl_m = 1'b1; q_wait(); q_wait();
            scl_m = 1'b0; q_wait();
        end
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        wr_bits(b, 8);
        sda_m = 1'b1; q_wait();
        scl_m = 1'b1; q_wait();
        ack = sda_line; q_wait();
        scl_m = 1'b0; q_wait();
    endtask

    task automatic rd_byte(output logic [7:0] b, input logic nack);
        sda_m = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            q_wait();
            scl_m = 1'b1; q_wait();
            b[i] = sda_line; q_wait();
            scl_m = 1'b0; q_wait();
        end
        sda_m = nack; q_wait();
        scl_m = 1'b1; q_wait(); q_wait();
        scl_m = 1'b0; q_wait();
        sda_m = 1'b1;
    endtask

    task automatic wr_reg(input logic [7:0] ptr, input logic [7:0] d);
        logic a;
        i2c_start();
        wr_byte(8'h54, a); chk("wr_reg_addr_ack", {7'b0, a}, 8'h00);
        wr_byte(ptr, a);   chk("wr_reg_ptr_ack", {7'b0, a}, 8'h00);
        wr_byte(d, a);     chk("wr_reg_data_ack", {7'b0, a}, 8'h00);
        i2c_stop();
    endtask

    task automatic wait_digit(input int idx, output logic [7:0] s);
        s = 'x;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk); #1;
            if (digit_sel == 4'(1 << idx)) begin
                s = seg_out;
                break;
            end
        end
    endtask

    initial begin
        logic       a;
        logic [7:0] b;
        logic [7:0] s;
        int         c0;
        logic [7:0] wdat [4];
        logic [7:0] wexp [4];
        logic [7:0] oexp [4];
        wdat = '{8'h01, 8'h02, 8'h8A, 8'h0F};
        wexp = '{8'h06, 8'h5B, 8'hF7, 8'h71};
        oexp = '{8'h6F, 8'h5B, 8'hF7, 8'h71};

        // reset state and idle multiplexing
        repeat (2) @(posedge clk); #1;
        chk("rst_sda_oe", {7'b0, sda_oe}, 8'h00);
        chk("rst_sel", {4'b0, digit_sel}, 8'h01);
        chk("rst_seg", seg_out, 8'h00);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("first_seg", seg_out, 8'h3F);
        chk("first_sel", {4'b0, digit_sel}, 8'h01);
        repeat (14) @(posedge clk); #1;
        chk("mux_hold", {4'b0, digit_sel}, 8'h01);
        for (int d = 1; d <= 4; d++) begin
            @(posedge clk); #1;
            chk("mux_sel", {4'b0, digit_sel}, 8'(1 << (d % 4)));
            chk("mux_seg", seg_out, 8'h3F);
            if (d < 4) repeat (15) @(posedge clk);
        end

        // burst write with auto-increment
        i2c_start();
        wr_byte(8'h54, a); chk("w_addr_ack", {7'b0, a}, 8'h00);
        wr_byte(8'h00, a); chk("w_ptr_ack", {7'b0, a}, 8'h00);
        for (int i = 0; i < 4; i++) begin
            wr_byte(wdat[i], a); chk("w_data_ack", {7'b0, a}, 8'h00);
        end
        i2c_stop();
        for (int i = 0; i < 4; i++) begin
            wait_digit(i, s); chk("w_digit", s, wexp[i]);
        end

        // raw mode and blanking
        wr_reg(8'h04, 8'h00);
        wr_reg(8'h00, 8'h49);
        wait_digit(0, s); chk("raw_digit0", s, 8'h49);
        wr_reg(8'h04, 8'h02);
        for (int i = 0; i < 4; i++) begin
            wait_digit(i, s); chk("blank_digit", s, 8'h00);
        end
        wr_reg(8'h04, 8'h01);

        // read with repeated start, wrap CTRL -> reg0
        i2c_start();
        wr_byte(8'h54, a); chk("r_waddr_ack", {7'b0, a}, 8'h00);
        wr_byte(8'h03, a); chk("r_ptr_ack", {7'b0, a}, 8'h00);
        i2c_rstart();
        wr_byte(8'h55, a); chk("r_raddr_ack", {7'b0, a}, 8'h00);
        rd_byte(b, 1'b0); chk("rd_reg3", b, 8'h0F);
        rd_byte(b, 1'b0); chk("rd_ctrl", b, 8'h01);
        rd_byte(b, 1'b1); chk("rd_reg0", b, 8'h49);
        chk("rd_release", {7'b0, sda_oe}, 8'h00);
        i2c_stop();

        // address mismatch
        c0 = oe_cnt;
        i2c_start();
        wr_byte(8'h56, a); chk("nomatch_nack", {7'b0, a}, 8'h01);
        chk("nomatch_oe_quiet", 8'(oe_cnt - c0), 8'h00);
        i2c_stop();
        wait_digit(1, s); chk("nomatch_digit1", s, 8'h5B);

        // out-of-range pointer
        wr_reg(8'h09, 8'hFF);
        for (int i = 0; i < 4; i++) begin
            wait_digit(i, s); chk("oor_digit", s, oexp[i]);
        end

        // STOP mid-byte discards the partial write
        i2c_start();
        wr_byte(8'h54, a); chk("ab_addr_ack", {7'b0, a}, 8'h00);
        wr_byte(8'h00, a); chk("ab_ptr_ack", {7'b0, a}, 8'h00);
        wr_bits(8'hA0, 4);
        i2c_stop();
        wait_digit(0, s); chk("ab_stop_digit0", s, 8'h6F);

        // reset mid-transfer
        i2c_start();
        wr_byte(8'h54, a); chk("rs_addr_ack", {7'b0, a}, 8'h00);
        wr_byte(8'h01, a); chk("rs_ptr_ack", {7'b0, a}, 8'h00);
        wr_bits(8'h00, 3);
        @(negedge clk) rst_n = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk("rs_sda_oe", {7'b0, sda_oe}, 8'h00);
        @(negedge clk) rst_n = 1'b1;
        wr_byte(8'h00, a); chk("rs_ignored_nack", {7'b0, a}, 8'h01);
        i2c_stop();
        wait_digit(0, s); chk("rs_digit0", s, 8'h3F);
        wait_digit(1, s); chk("rs_digit1", s, 8'h3F);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/i2c_segment_display_ctrl.md
# i2c_segment_display_ctrl

I2C target that lets an external controller write digit and control registers and drives a multiplexed multi-digit 7-segment display from them. It succeeds the single-switch pass-through segment top: it adds a real I2C slave, a register file with auto-increment and read-back, a parametrised digit count, and hex-decode or raw-segment modes. It sits directly behind the top-level pin wrapper: SCL/SDA on bidirectional pins, segments on dedicated outputs, digit enables on the remaining bidirectional pins.

## Interface
- `I2C_ADDR`, 7'h2A, 7-bit target address.
- `NUM_DIGITS`, 4, number of digits and digit registers (1..8).
- `MUX_DIV`, 1024, clk cycles each digit is shown (≥2).
- `clk  in  1`, single clock; must be ≥16× the SCL frequency.
- `rst_n  in  1`, synchronous, active-low reset.
- `scl_in  in  1`, SCL pin level (asynchronous).
- `sda_in  in  1`, SDA pin level (asynchronous).
- `sda_oe  out  1`, 1 = pull SDA low (open-drain); block never drives high.
- `seg_out  out  8`, active-high segments, bit0=a … bit6=g, bit7=dp.
- `digit_sel  out  NUM_DIGITS`, one-hot active-high digit enable.

## Operation
- SCL/SDA pass through 2-flop synchronisers, then one register for edge detection. START = SDA fall while SCL high; STOP = SDA rise while SCL high. Bits sampled on SCL rising edge, MSB first.
- Register map: 0..NUM_DIGITS-1 = digit data (reset 8'h00); NUM_DIGITS = CTRL (reset 8'h01): bit0 HEX (1 = decode data[3:0] to glyph, data[7] → dp; 0 = data is raw segment pattern), bit1 BLANK (1 = seg_out forced 0), bits 7:2 read as 0, writes ignored.
- FSM: IDLE → ADDR on START. ADDR shifts 8 bits; on match with R/W=0 → ACK_A → PTR; R/W=1 → ACK_A → RDATA; mismatch → no ACK, IDLE. PTR: 8 bits into pointer → ACK_P → WDATA. WDATA: 8 bits → write reg[ptr], ACK_W, ptr+1 → WDATA. RDATA: shift out reg[ptr] (sda_oe = ~bit) → ACKWAIT samples master ACK: ACK (SDA low) → ptr+1, RDATA; NACK → IDLE.
- START in any state (repeated start) → ADDR, pointer retained. STOP in any state → IDLE, sda_oe released.
- Pointer is 8 bits; auto-increment wraps from NUM_DIGITS to 0. Pointer > NUM_DIGITS: writes ACKed but discarded, reads return 8'h00, increment still wraps to 0.
- Hex glyphs: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- Mux: counter 0..MUX_DIV-1; at terminal count digit index advances, wrapping NUM_DIGITS-1 → 0. digit_sel and seg_out registered, change in the same cycle.

## Timing
- Reset (rst_n low at a clk edge): FSM IDLE, sda_oe=0, pointer=0, registers to reset values, mux counter 0, digit_sel=1, seg_out=0; first cycle after reset seg_out=8'h3F (digit 0, HEX, value 0).
- Reset mid-transaction aborts it; bus ignored until next START.
- Synchroniser latency: 3 clk from pin change to detected edge.
- ACK/data drive: sda_oe updated 1 clk after detected SCL falling edge; held until the next detected SCL falling edge (ACK released there).
- Register write takes effect the clk after the 8th data-bit rising edge; visible on seg_out at the next clk edge if that digit is selected.
- Read data byte is latched at ACK_A / ACKWAIT completion; a write to the same reg after latching does not alter the byte in flight.

## Test plan
- Reset: hold rst_n low 2 clk → sda_oe=0, digit_sel=4'b0001, seg_out=8'h3F after release; all digits cycle every MUX_DIV clk showing 3F.
- Write: START, 0x54, ptr 0x00, data 0x01 0x02 0x8A 0x0F, STOP → four ACKs+addr/ptr ACKs; digits show 06, 5B, F7, 71.
- Raw/blank: write CTRL (ptr 0x04) = 0x00 then digit0 = 0x49 → seg_out 0x49 on digit 0; CTRL = 0x02 → seg_out 0x00 on all digits.
- Read with repeated start: write ptr 0x03, Sr, 0x55, read 3 bytes ACK,ACK,NACK → returns reg3, CTRL, reg0 (wrap); sda released after NACK.
- Address mismatch: START, 0x56 → no ACK, sda_oe stays 0 for entire byte, registers unchanged.
- Out-of-range and abort: write ptr 0x09 data 0xFF → ACKed, no register changed; mid-byte STOP, then rst_n pulse mid-transfer → IDLE, sda_oe=0, registers at reset values.
